// File: rtl/ysyx_23060236_icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the FSM state encoding and a small width helper.
package ysyx_23060236_icache_sa_pkg;

  typedef enum logic [2:0] {
    IC_IDLE   = 3'd0,
    IC_LOOKUP = 3'd1,
    IC_AR     = 3'd2,
    IC_REFILL = 3'd3,
    IC_RESP   = 3'd4
  } ic_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060236_icache_sa_way.sv
// One cache way: tag, valid and data arrays for every set.
// Valid bits reset to zero; tag and data arrays are left unreset.
import ysyx_23060236_icache_sa_pkg::*;

module ysyx_23060236_icache_sa_way #(
  parameter int TAG_LEN  = 19,
  parameter int IDX_W    = 2,
  parameter int SETS     = 4,
  parameter int OFF_W    = 2,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_W-1:0]    idx,
  input  logic [TAG_LEN-1:0]  tag,
  input  logic [OFF_W-1:0]    rd_off,
  output logic                hit,
  output logic                valid,
  output logic [DATA_LEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [OFF_W-1:0]    wr_off,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                tag_we,
  input  logic                valid_set,
  input  logic                valid_clr,
  input  logic                inval_all
);

  localparam int WORDS = 1 << OFF_W;

  logic [TAG_LEN-1:0]  tags [SETS];
  logic [DATA_LEN-1:0] data [SETS][WORDS];
  logic [SETS-1:0]     valids;

  assign valid   = valids[idx];
  assign hit     = valid && (tags[idx] == tag);
  assign rd_data = data[idx][rd_off];

  always_ff @(posedge clock) begin
    if (wr_en)  data[idx][wr_off] <= wr_data;
    if (tag_we) tags[idx] <= tag;
  end

  // Invalidate-all wins over a set landing in the same cycle
  always_ff @(posedge clock) begin
    if (reset || inval_all) valids <= '0;
    else if (valid_set)     valids[idx] <= 1'b1;
    else if (valid_clr)     valids[idx] <= 1'b0;
  end

endmodule

// File: rtl/ysyx_23060236_icache_sa.sv
// N-way set-associative icache: FSM, victim pointers, refill
// beat counter and response mux around WAYS way instances.
import ysyx_23060236_icache_sa_pkg::*;

module ysyx_23060236_icache_sa #(
  parameter int ADDR_LEN   = 25,
  parameter int DATA_LEN   = 32,
  parameter int OFFSET_LEN = 4,
  parameter int INDEX_LEN  = 2,
  parameter int WAYS       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_LEN-1:0] req_addr,
  output logic                resp_valid,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_err,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [ADDR_LEN-1:0] mem_araddr,
  output logic [7:0]          mem_arlen,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [DATA_LEN-1:0] mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rlast,
  input  logic                fence_i
);

  localparam int TAG_LEN = ADDR_LEN - INDEX_LEN - OFFSET_LEN;
  localparam int OFF_W   = OFFSET_LEN - 2;
  localparam int BLOCK_WORDS = 1 << OFF_W;
  localparam int SETS    = 1 << INDEX_LEN;
  localparam int IDX_W   = (INDEX_LEN > 0) ? INDEX_LEN : 1;
  localparam int WAY_W   = clog2_min1(WAYS);

  ic_state_e           state;
  logic [ADDR_LEN-1:0] a_q;
  logic [WAY_W-1:0]    vic_q;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    vptr [SETS];
  logic [OFF_W-1:0]    beat;
  logic                err_q;
  logic                drop_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_LEN-1:0]  tag;
  logic [OFF_W-1:0]    off;
  logic [WAYS-1:0]     hit_w;
  logic [WAYS-1:0]     valid_w;
  logic [DATA_LEN-1:0] rd_w [WAYS];
  logic                hit_any;
  logic                beat_fire;
  logic                last_beat;
  logic                err_fin;
  logic                unused_bits;

  assign tag = a_q[ADDR_LEN-1 -: TAG_LEN];
  assign off = a_q[OFFSET_LEN-1:2];

  if (INDEX_LEN > 0) begin : g_idx
    assign idx = a_q[OFFSET_LEN +: IDX_W];
  end else begin : g_noidx
    assign idx = '0;
  end

  assign unused_bits = ^{a_q[1:0], mem_rlast};

  assign hit_any   = |hit_w;
  assign beat_fire = (state == IC_REFILL) && mem_rvalid;
  assign last_beat = (beat == OFF_W'(BLOCK_WORDS - 1));
  assign err_fin   = err_q | (|mem_rresp);

  assign req_ready   = (state == IC_IDLE);
  assign mem_arvalid = (state == IC_AR);
  assign mem_rready  = (state == IC_REFILL);
  assign mem_araddr  = {a_q[ADDR_LEN-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
  assign mem_arlen   = 8'(BLOCK_WORDS - 1);
  assign resp_valid  = ((state == IC_LOOKUP) && hit_any) || (state == IC_RESP);
  assign resp_err    = (state == IC_RESP) && err_q;

  // Lowest invalid way first, otherwise round-robin
  always_comb begin
    victim = vptr[idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_w[w]) victim = WAY_W'(w);
  end

  always_comb begin
    resp_data = rd_w[vic_q];
    if (state == IC_LOOKUP)
      for (int w = 0; w < WAYS; w++)
        if (hit_w[w]) resp_data = rd_w[w];
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic sel;
    logic fill;
    assign sel  = (vic_q == WAY_W'(w));
    assign fill = beat_fire && sel;

    ysyx_23060236_icache_sa_way #(
      .TAG_LEN  (TAG_LEN),
      .IDX_W    (IDX_W),
      .SETS     (SETS),
      .OFF_W    (OFF_W),
      .DATA_LEN (DATA_LEN)
    ) u_way (
      .clock     (clock),
      .reset     (reset),
      .idx       (idx),
      .tag       (tag),
      .rd_off    (off),
      .hit       (hit_w[w]),
      .valid     (valid_w[w]),
      .rd_data   (rd_w[w]),
      .wr_en     (fill),
      .wr_off    (beat),
      .wr_data   (mem_rdata),
      .tag_we    (fill && last_beat),
      .valid_set (fill && last_beat && !err_fin && !drop_q),
      .valid_clr ((state == IC_LOOKUP) && !hit_any
                  && (victim == WAY_W'(w))),
      .inval_all (fence_i)
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IC_IDLE;
      a_q    <= '0;
      vic_q  <= '0;
      beat   <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else begin
      unique case (state)
        IC_IDLE: begin
          if (req_valid) begin
            a_q   <= req_addr;
            state <= IC_LOOKUP;
          end
        end
        IC_LOOKUP: begin
          if (hit_any) begin
            state <= IC_IDLE;
          end else begin
            vic_q     <= victim;
            vptr[idx] <= (vptr[idx] == WAY_W'(WAYS - 1))
                         ? '0 : vptr[idx] + WAY_W'(1);
            state     <= IC_AR;
          end
        end
        IC_AR: begin
          if (mem_arready) begin
            beat  <= '0;
            state <= IC_REFILL;
          end
        end
        IC_REFILL: begin
          if (mem_rvalid) begin
            err_q <= err_fin;
            if (last_beat) state <= IC_RESP;
            else           beat  <= beat + OFF_W'(1);
          end
        end
        IC_RESP: begin
          err_q  <= 1'b0;
          drop_q <= 1'b0;
          state  <= IC_IDLE;
        end
        default: state <= IC_IDLE;
      endcase
      // In-flight line must not become valid after a fence
      if (fence_i && (state == IC_AR || state == IC_REFILL))
        drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_icache_sa.sv
// Self-checking bench for the set-associative icache:
// table of fetches plus hand sequences for fence/error/stall/reset.
module tb_ysyx_23060236_icache_sa;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [24:0] req_addr = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_arvalid;
  logic        mem_arready = 1'b0;
  logic [24:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        mem_rlast = 1'b0;
  logic        fence_i = 1'b0;

  ysyx_23060236_icache_sa dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_araddr  (mem_araddr),
    .mem_arlen   (mem_arlen),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rlast   (mem_rlast),
    .fence_i     (fence_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [24:0] addr;
    bit          miss;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs [14];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    if (a[24:4] == 21'h4) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return {7'h55, a[24:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_cmp(input string name);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got response expected none queued", name);
      return;
    end
    n_tests--;
    e = exp_q.pop_front();
    chk({name, "_data"}, resp_data, e.data);
    chk({name, "_err"}, 32'(resp_err), 32'(e.err));
  endtask

  // fence_at: -2 none, -1 with acceptance, >=0 on that refill beat
  task automatic fetch(input logic [24:0] a, input bit exp_miss,
                       input int ar_wait, input int err_beat,
                       input int rst_beat, input int fence_at);
    exp_t e;
    bit missed;
    logic [24:0] line;
    line = {a[24:4], 4'b0};
    req_valid = 1'b1;
    req_addr  = a;
    fence_i   = (fence_at == -1);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    e.data = mem_word(a);
    e.err  = (err_beat >= 0);
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    fence_i   = 1'b0;
    missed = !resp_valid;
    chk($sformatf("miss_%h", a), 32'(missed), 32'(exp_miss));
    if (!missed) begin
      pop_cmp("hit");
      tick();
      return;
    end
    tick();
    chk("arvalid", 32'(mem_arvalid), 32'd1);
    chk("araddr", 32'(mem_araddr), 32'(line));
    chk("arlen", 32'(mem_arlen), 32'd3);
    for (int i = 0; i < ar_wait; i++) begin
      mem_arready = 1'b0;
      tick();
      chk("arvalid_hold", 32'(mem_arvalid), 32'd1);
      chk("araddr_hold", 32'(mem_araddr), 32'(line));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
    end
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("rready", 32'(mem_rready), 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(line | 25'(b * 4));
      mem_rresp  = (b == err_beat) ? 2'd2 : 2'd0;
      mem_rlast  = (b == 3);
      fence_i    = (b == fence_at);
      if (b == rst_beat) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rready", 32'(mem_rready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        void'(exp_q.pop_front());
        return;
      end
      tick();
      mem_rvalid = 1'b0;
      mem_rresp  = 2'd0;
      mem_rlast  = 1'b0;
      fence_i    = 1'b0;
    end
    chk("resp_valid_refill", 32'(resp_valid), 32'd1);
    if (resp_valid) pop_cmp("refill");
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{25'h040, 1'b1};
    vecs[1]  = '{25'h044, 1'b0};
    vecs[2]  = '{25'h04C, 1'b0};
    vecs[3]  = '{25'h010, 1'b1};
    vecs[4]  = '{25'h110, 1'b1};
    vecs[5]  = '{25'h114, 1'b0};
    vecs[6]  = '{25'h210, 1'b1};
    vecs[7]  = '{25'h118, 1'b0};
    vecs[8]  = '{25'h214, 1'b0};
    vecs[9]  = '{25'h010, 1'b1};
    vecs[10] = '{25'h218, 1'b0};
    vecs[11] = '{25'h110, 1'b1};
    vecs[12] = '{25'h018, 1'b0};
    vecs[13] = '{25'h21C, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_arvalid", 32'(mem_arvalid), 32'd0);
    chk("rst_rready", 32'(mem_rready), 32'd0);

    for (int i = 0; i < 14; i++)
      fetch(vecs[i].addr, vecs[i].miss, 0, -1, -1, -2);

    // fence in IDLE drops the set-0 line
    fence_i = 1'b1;
    tick();
    fence_i = 1'b0;
    fetch(25'h044, 1'b1, 0, -1, -1, -2);
    fetch(25'h048, 1'b0, 0, -1, -1, -2);

    // fence mid-refill
    fetch(25'h084, 1'b1, 0, -1, -1, 1);
    fetch(25'h080, 1'b1, 0, -1, -1, -2);
    fetch(25'h040, 1'b1, 0, -1, -1, -2);
    fetch(25'h114, 1'b1, 0, -1, -1, -2);

    // error beat
    fetch(25'h0C0, 1'b1, 0, 1, -1, -2);
    fetch(25'h0C4, 1'b1, 0, -1, -1, -2);
    fetch(25'h0C8, 1'b0, 0, -1, -1, -2);

    // AR stall
    fetch(25'h300, 1'b1, 5, -1, -1, -2);
    fetch(25'h304, 1'b0, 0, -1, -1, -2);

    // reset mid-refill
    fetch(25'h080, 1'b0, 0, -1, -1, -2);
    fetch(25'h400, 1'b1, 0, -1, 2, -2);
    fetch(25'h080, 1'b1, 0, -1, -1, -2);
    fetch(25'h084, 1'b0, 0, -1, -1, -2);

    // fence coincident with acceptance
    fetch(25'h088, 1'b1, 0, -1, -1, -1);
    fetch(25'h08C, 1'b0, 0, -1, -1, -2);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
